sub_64bit_pipe: RTL and testbench

Two-stage pipelined 64-bit subtractor with valid/ready handshakes, the inverse of the team's pipelined carry-lookahead adder. It computes `in_a - in_b - in_borrow` with borrow-out, signed overflow, zero and signed-less-than flags. It sustains one operation per cycle under backpressure and sits in the ALU datapath beside the adder.

---
 rtl/sub_64bit_pipe_if.sv | 28 ++
 rtl/sub_64bit_pipe.sv | 123 ++++++++++++
 tb/tb_sub_64bit_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_64bit_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// The master side drives operands and consumes results; the slave side is the subtractor.
interface sub_64bit_pipe_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_borrow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_d;
  logic             out_borrow;
  logic             out_overflow;
  logic             out_zero;
  logic             out_lt_s;

  modport master (
    output in_valid, in_a, in_b, in_borrow, out_ready,
    input  in_ready, out_valid, out_d, out_borrow, out_overflow, out_zero, out_lt_s
  );

  modport slave (
    input  in_valid, in_a, in_b, in_borrow, out_ready,
    output in_ready, out_valid, out_d, out_borrow, out_overflow, out_zero, out_lt_s
  );
endinterface

// File: rtl/sub_64bit_pipe.sv
// Two-stage pipelined subtractor: a - b - borrow computed as a + ~b + ~borrow with a
// radix-2 group prefix tree. S1 holds bitwise and 2-bit group g/p, S2 finishes the tree.
module sub_64bit_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input logic              clk,
  input logic              rstn,
  sub_64bit_pipe_if.slave  bus
);
  localparam int unsigned NumGrp = WIDTH / 2;
  localparam int unsigned NumLvl = $clog2(NumGrp);

  logic                s1_valid_q;
  logic [WIDTH-1:0]    a_q, nb_q, g_q, p_q;
  logic                cin_q;
  logic [NumGrp-1:0]   gg_q, gp_q;

  logic                out_valid_q;
  logic [WIDTH-1:0]    out_d_q;
  logic                out_borrow_q, out_overflow_q, out_zero_q, out_lt_s_q;

  logic                s2_free, s1_move, accept;
  logic [WIDTH-1:0]    nb_in, g_in, p_in;
  logic [NumGrp-1:0]   gg_in, gp_in;

  logic [NumGrp-1:0]   gk, pk, gn, pn;
  logic [NumGrp:0]     cg;
  logic [WIDTH-1:0]    carry, sum;
  logic                cout, ovf;

  // Operands and odd-bit generates ride along in S1 but the sum only needs p and the carries.
  logic                unused_s1;
  assign unused_s1 = ^{a_q, nb_q, g_q};

  assign s2_free      = ~out_valid_q | bus.out_ready;
  assign s1_move      = s1_valid_q & s2_free;
  assign bus.in_ready = rstn & (~s1_valid_q | s2_free);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    nb_in = ~bus.in_b;
    g_in  = bus.in_a & nb_in;
    p_in  = bus.in_a ^ nb_in;
    gg_in = '0;
    gp_in = '0;
    for (int j = 0; j < int'(NumGrp); j++) begin
      gg_in[j] = g_in[2*j+1] | (p_in[2*j+1] & g_in[2*j]);
      gp_in[j] = p_in[2*j+1] & p_in[2*j];
    end
  end

  // Kogge-Stone over the 2-bit groups, then expand back to per-bit carries.
  always_comb begin
    gk = gg_q;
    pk = gp_q;
    gn = '0;
    pn = '0;
    for (int l = 0; l < int'(NumLvl); l++) begin
      gn = gk;
      pn = pk;
      for (int j = (1 << l); j < int'(NumGrp); j++) begin
        gn[j] = gk[j] | (pk[j] & gk[j-(1<<l)]);
        pn[j] = pk[j] & pk[j-(1<<l)];
      end
      gk = gn;
      pk = pn;
    end
    cg    = {gk | (pk & {NumGrp{cin_q}}), cin_q};
    carry = '0;
    for (int j = 0; j < int'(NumGrp); j++) begin
      carry[2*j]   = cg[j];
      carry[2*j+1] = g_q[2*j] | (p_q[2*j] & cg[j]);
    end
    sum  = p_q ^ carry;
    cout = cg[NumGrp];
    ovf  = carry[WIDTH-1] ^ cout;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q     <= 1'b0;
      a_q            <= '0;
      nb_q           <= '0;
      g_q            <= '0;
      p_q            <= '0;
      cin_q          <= 1'b0;
      gg_q           <= '0;
      gp_q           <= '0;
      out_valid_q    <= 1'b0;
      out_d_q        <= '0;
      out_borrow_q   <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_lt_s_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.in_a;
        nb_q  <= nb_in;
        g_q   <= g_in;
        p_q   <= p_in;
        cin_q <= ~bus.in_borrow;
        gg_q  <= gg_in;
        gp_q  <= gp_in;
      end
      s1_valid_q <= accept | (s1_valid_q & ~s2_free);
      if (s1_move) begin
        out_d_q        <= sum;
        out_borrow_q   <= ~cout;
        out_overflow_q <= ovf;
        out_zero_q     <= (sum == '0);
        out_lt_s_q     <= sum[WIDTH-1] ^ ovf;
      end
      out_valid_q <= s1_move | (out_valid_q & ~bus.out_ready);
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_d        = out_d_q;
  assign bus.out_borrow   = out_borrow_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_lt_s     = out_lt_s_q;
endmodule

// File: tb/tb_sub_64bit_pipe.sv
// Self-checking bench for sub_64bit_pipe: directed corner vectors, streaming with and
// without backpressure against a wide-arithmetic reference model, and reset mid-flight.
module tb_sub_64bit_pipe;
  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        v;
    logic        z;
    logic        l;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sub_64bit_pipe_if #(.WIDTH(64)) bus ();

  sub_64bit_pipe #(.WIDTH(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: unsigned borrow from a 65-bit difference, signed flags from sign-extended operands.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic br);
    res_t               r;
    logic        [64:0] u;
    logic signed [64:0] s;
    u   = {1'b0, a} - {1'b0, b} - {64'd0, br};
    s   = $signed({a[63], a}) - $signed({b[63], b}) - $signed({64'd0, br});
    r.d = u[63:0];
    r.b = u[64];
    r.v = s[64] ^ s[63];
    r.l = s[64];
    r.z = (u[63:0] == 64'd0);
    return r;
  endfunction

  function automatic res_t sample_out();
    return {bus.out_d, bus.out_borrow, bus.out_overflow, bus.out_zero, bus.out_lt_s};
  endfunction

  task automatic rand_op(output logic [63:0] a, output logic [63:0] b, output logic br);
    int sel;
    sel = $urandom_range(0, 3);
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    br  = 1'($urandom_range(0, 1));
    if (sel == 1) b = a;
    if (sel == 2) b = '1;
    if (sel == 3) a = {32'd0, 28'd0, 4'($urandom)};
  endtask

  task automatic test_reset();
    res_t o;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_borrow = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    o = sample_out();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [7];
    logic [63:0] tb [7];
    logic        tbr [7];
    res_t        te [7];
    res_t        o;
    ta[0] = 64'd5;                  tb[0] = 64'd5;        tbr[0] = 1'b0;
    ta[1] = 64'd0;                  tb[1] = 64'd1;        tbr[1] = 1'b0;
    ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'd1;        tbr[2] = 1'b0;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = '1;           tbr[3] = 1'b0;
    ta[4] = 64'h1_0000_0000;        tb[4] = 64'd0;        tbr[4] = 1'b1;
    ta[5] = 64'd0;                  tb[5] = 64'd0;        tbr[5] = 1'b1;
    ta[6] = 64'h1234_5678_9ABC_DEF0; tb[6] = '1;           tbr[6] = 1'b1;
    te[0] = {64'd0,                  1'b0, 1'b0, 1'b1, 1'b0};
    te[1] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    te[2] = {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    te[3] = {64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    te[4] = {64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    te[5] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    te[6] = {64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = ta[i];
      bus.in_b      = tb[i];
      bus.in_borrow = tbr[i];
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_early_valid: got %b want 0", i, bus.out_valid);
      end
      @(negedge clk);
      o = sample_out();
      checks++;
      if (bus.out_valid !== 1'b1 || o !== te[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got valid=%b %h want valid=1 %h",
                 i, bus.out_valid, o, te[i]);
      end
    end
  endtask

  task automatic test_stream(input string name, input int n, input bit bp);
    res_t        q [$];
    res_t        obs, prev, exp_r;
    logic [63:0] a, b;
    logic        br;
    logic        exp_ir;
    bit          prev_stall;
    int          sent, got_n, cyc;
    sent       = 0;
    got_n      = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev       = '0;
    rand_op(a, b, br);
    while ((sent < n || q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      obs = sample_out();
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== prev) begin
          errors++;
          $display("FAIL %s_stall_hold: got valid=%b %h want valid=1 %h",
                   name, bus.out_valid, obs, prev);
        end
      end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid  = (sent < n);
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_borrow = br;
      #1;
      exp_ir = !(q.size() == 2 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_ir) begin
        errors++;
        $display("FAIL %s_in_ready: got %b want %b (inflight=%0d)",
                 name, bus.in_ready, exp_ir, q.size());
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_result: got %h want none", name, obs);
        end else begin
          exp_r = q.pop_front();
          got_n++;
          if (obs !== exp_r) begin
            errors++;
            $display("FAIL %s_result%0d: got %h want %h", name, got_n, obs, exp_r);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(a, b, br));
        sent++;
        rand_op(a, b, br);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = obs;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got_n != n || q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d results want %0d", name, got_n, n);
    end
    if (!bp) begin
      checks++;
      if (cyc != n + 2) begin
        errors++;
        $display("FAIL %s_throughput: got %0d cycles want %0d", name, cyc, n + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t o;
    res_t e;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 64'd11;
    bus.in_b      = 64'd2;
    bus.in_borrow = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept1: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_a = 64'd12;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept2: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_full: got in_ready=%b out_valid=%b want 0 1",
               bus.in_ready, bus.out_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_ready_comb: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    o = sample_out();
    checks++;
    if (bus.out_valid !== 1'b0 || o !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared: got valid=%b in_ready=%b %h want 0 0 0",
               bus.out_valid, bus.in_ready, o);
    end
    rstn          = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 64'd10;
    bus.in_b      = 64'd3;
    bus.in_borrow = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: got valid=%b d=%h want valid=0", bus.out_valid, bus.out_d);
    end
    @(negedge clk);
    o = sample_out();
    e = {64'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (bus.out_valid !== 1'b1 || o !== e) begin
      errors++;
      $display("FAIL midrst_result: got valid=%b %h want valid=1 %h", bus.out_valid, o, e);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drain: got valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream("back_to_back", 20, 1'b0);
    test_stream("backpressure", 24, 1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
